// File: rtl/flight_state_integrator.sv
// flight_state_integrator
// Integrates acceleration samples into vertical velocity and height using
// semi-implicit Euler (dt = 1 sample). Velocity is saturated to the signed
// N-bit range. Height is clamped to [0, 2^(N-1)-1]. A small phase FSM tracks
// pad, ascent, hold and landed conditions.

module flight_state_integrator #(
   parameter int          N        = 64,
   parameter logic [63:0] GATE_ALT = 64'd30000000000000
) (
   input  logic         clk,
   input  logic         resetb,
   input  logic         launch,
   input  logic         hold,
   input  logic         accel_valid,
   input  logic [N-1:0] accel,
   output logic [N-1:0] velocity,
   output logic [N-1:0] height,
   output logic         out_valid,
   output logic [1:0]   phase,
   output logic         above_gate
);

   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_ASCENT = 2'd1,
      PH_HOLD   = 2'd2,
      PH_LANDED = 2'd3
   } phase_t;

   // Gate comparison width: wide enough for both height and the 64-bit threshold
   localparam int CW = (N > 64) ? N : 64;

   localparam logic [N-1:0] VMAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] VMIN = {1'b1, {(N-1){1'b0}}};

   phase_t       phaseQ, phaseD;
   logic [N-1:0] velocityQ, velocityD;
   logic [N-1:0] heightQ, heightD;
   logic         outValidQ, outValidD;
   logic         aboveGateQ, aboveGateD;
   logic         airborneQ, airborneD;

   logic [N:0]   vSum;
   logic [N-1:0] vSat;
   logic [N:0]   hRaw;
   logic         hPositive;
   logic         hOver;

   // Candidate integration step: saturated velocity, then raw height (N+1 bits signed)
   always_comb begin
      vSum = {velocityQ[N-1], velocityQ} + {accel[N-1], accel};
      vSat = vSum[N-1:0];
      if (vSum[N] != vSum[N-1]) begin
         vSat = vSum[N] ? VMIN : VMAX;
      end
      hRaw      = {1'b0, heightQ} + {vSat[N-1], vSat};
      hPositive = !hRaw[N] && (hRaw != '0);
      hOver     = !hRaw[N] && hRaw[N-1];
   end

   // Phase transitions and next values of the integrator state
   always_comb begin
      phaseD     = phaseQ;
      velocityD  = velocityQ;
      heightD    = heightQ;
      outValidD  = 1'b0;
      airborneD  = airborneQ;
      aboveGateD = 1'b0;

      unique case (phaseQ)
         PH_IDLE: begin
            if (launch) begin
               phaseD = PH_ASCENT;
            end
         end
         PH_ASCENT: begin
            if (hold) begin
               phaseD = PH_HOLD;
            end else if (accel_valid) begin
               outValidD = 1'b1;
               if (hPositive) begin
                  velocityD = vSat;
                  heightD   = hOver ? VMAX : hRaw[N-1:0];
                  airborneD = 1'b1;
               end else begin
                  velocityD = '0;
                  heightD   = '0;
                  if (airborneQ) begin
                     phaseD = PH_LANDED;
                  end
               end
            end
         end
         PH_HOLD: begin
            if (!hold) begin
               phaseD = PH_ASCENT;
            end
         end
         PH_LANDED: begin
            if (launch) begin
               phaseD    = PH_IDLE;
               velocityD = '0;
               heightD   = '0;
               airborneD = 1'b0;
            end
         end
         default: begin
            phaseD = PH_IDLE;
         end
      endcase

      if (phaseD != PH_IDLE) begin
         aboveGateD = (CW'(heightD) > CW'(GATE_ALT));
      end
   end

   // State registers; reset clears everything immediately
   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         phaseQ     <= PH_IDLE;
         velocityQ  <= '0;
         heightQ    <= '0;
         outValidQ  <= 1'b0;
         aboveGateQ <= 1'b0;
         airborneQ  <= 1'b0;
      end else begin
         phaseQ     <= phaseD;
         velocityQ  <= velocityD;
         heightQ    <= heightD;
         outValidQ  <= outValidD;
         aboveGateQ <= aboveGateD;
         airborneQ  <= airborneD;
      end
   end

   assign velocity   = velocityQ;
   assign height     = heightQ;
   assign out_valid  = outValidQ;
   assign phase      = phaseQ;
   assign above_gate = aboveGateQ;

endmodule

// File: tb/tb_flight_state_integrator.sv
// Directed bench for flight_state_integrator. dutA uses the default N=64
// configuration; dutB uses N=8 with GATE_ALT=10 for saturation and gate work.

module tb_flight_state_integrator;

   logic        clk;
   logic        resetb;
   logic        launch;
   logic        hold;
   logic        accelValid;
   logic [63:0] accelA;
   logic [7:0]  accelB;

   logic [63:0] velA, hgtA;
   logic        ovA, agA;
   logic [1:0]  phA;
   logic [7:0]  velB, hgtB;
   logic        ovB, agB;
   logic [1:0]  phB;

   int checks = 0;
   int errors = 0;

   flight_state_integrator dutA (
      .clk(clk), .resetb(resetb), .launch(launch), .hold(hold),
      .accel_valid(accelValid), .accel(accelA),
      .velocity(velA), .height(hgtA), .out_valid(ovA),
      .phase(phA), .above_gate(agA)
   );

   flight_state_integrator #(.N(8), .GATE_ALT(64'd10)) dutB (
      .clk(clk), .resetb(resetb), .launch(launch), .hold(hold),
      .accel_valid(accelValid), .accel(accelB),
      .velocity(velB), .height(hgtB), .out_valid(ovB),
      .phase(phB), .above_gate(agB)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge
   task automatic applyStimulus(input logic l, input logic h, input logic v,
                                input logic signed [63:0] aA,
                                input logic signed [7:0] aB);
      launch     = l;
      hold       = h;
      accelValid = v;
      accelA     = aA;
      accelB     = aB;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkA(input string tag, input logic signed [63:0] v,
                         input logic signed [63:0] h, input logic ov, input logic [1:0] ph);
      checkOutput({tag, ".A.vel"}, velA, v);
      checkOutput({tag, ".A.hgt"}, hgtA, h);
      checkOutput({tag, ".A.ov"}, 64'(ovA), 64'(ov));
      checkOutput({tag, ".A.phase"}, 64'(phA), 64'(ph));
   endtask

   task automatic checkB(input string tag, input logic signed [63:0] v,
                         input logic signed [63:0] h, input logic ov, input logic [1:0] ph,
                         input logic ag);
      checkOutput({tag, ".B.vel"}, 64'($signed(velB)), v);
      checkOutput({tag, ".B.hgt"}, 64'($signed(hgtB)), h);
      checkOutput({tag, ".B.ov"}, 64'(ovB), 64'(ov));
      checkOutput({tag, ".B.phase"}, 64'(phB), 64'(ph));
      checkOutput({tag, ".B.gate"}, 64'(agB), 64'(ag));
   endtask

   task automatic doReset();
      resetb = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      resetb = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
   endtask

   // Linear sequence of directed steps with hand-computed expectations
   initial begin
      resetb = 1'b1; launch = 0; hold = 0; accelValid = 0; accelA = '0; accelB = '0;
      #12;
      checkA("reset", 0, 0, 0, 0);
      checkOutput("reset.A.gate", 64'(agA), 0);
      doReset();

      // IDLE ignores samples
      applyStimulus(0, 0, 1, 2, 0);
      checkA("idle_ignore", 0, 0, 0, 0);

      // Basic integration
      applyStimulus(1, 0, 0, 0, 0);
      checkA("launch", 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 2, 0);
      checkA("int1", 2, 2, 1, 1);
      applyStimulus(0, 0, 1, 2, 0);
      checkA("int2", 4, 6, 1, 1);
      applyStimulus(0, 0, 1, 2, 0);
      checkA("int3", 6, 12, 1, 1);
      checkOutput("int3.A.gate", 64'(agA), 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkA("novalid", 6, 12, 0, 1);

      // Landing
      applyStimulus(0, 0, 1, -10, 0);
      checkA("land1", -4, 8, 1, 1);
      applyStimulus(0, 0, 1, -10, 0);
      checkA("land2", 0, 0, 1, 3);
      applyStimulus(0, 1, 1, 5, 0);
      checkA("landed_frozen", 0, 0, 0, 3);
      applyStimulus(1, 0, 0, 0, 0);
      checkA("rearm", 0, 0, 0, 0);

      // Pad hold-down: airborne cleared by re-arm, so no landing
      applyStimulus(1, 0, 0, 0, 0);
      checkA("pad_launch", 0, 0, 0, 1);
      applyStimulus(0, 0, 1, -5, 0);
      checkA("pad", 0, 0, 1, 1);

      // Climb to h=12 then assert reset between edges
      applyStimulus(0, 0, 1, 2, 0);
      applyStimulus(0, 0, 1, 2, 0);
      applyStimulus(0, 0, 1, 2, 0);
      checkA("preasync", 6, 12, 1, 1);
      #2;
      resetb = 1'b1;
      #1;
      checkA("async", 0, 0, 0, 0);
      resetb = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);

      // Saturation on the 8-bit instance
      doReset();
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 100);
      checkB("sat1", 100, 100, 1, 1, 1);
      applyStimulus(0, 0, 1, 0, 100);
      checkB("sat2", 127, 127, 1, 1, 1);
      applyStimulus(0, 0, 1, 0, -128);
      checkB("sat3", -1, 126, 1, 1, 1);
      applyStimulus(0, 0, 1, 0, -128);
      checkB("sat4_noWrap", 0, 0, 1, 3, 0);
      applyStimulus(0, 0, 1, 0, -128);
      checkB("sat5", 0, 0, 0, 3, 0);

      // Gate and hold on the 8-bit instance
      doReset();
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 2);
      checkB("gate1", 2, 2, 1, 1, 0);
      applyStimulus(0, 0, 1, 0, 2);
      checkB("gate2", 4, 6, 1, 1, 0);
      applyStimulus(0, 0, 1, 0, 2);
      checkB("gate3", 6, 12, 1, 1, 1);
      applyStimulus(0, 1, 1, 0, 2);
      checkB("hold1", 6, 12, 0, 2, 1);
      applyStimulus(1, 1, 1, 0, 2);
      checkB("hold2", 6, 12, 0, 2, 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkB("release", 6, 12, 0, 1, 1);
      applyStimulus(0, 0, 1, 0, 2);
      checkB("resume", 8, 20, 1, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #100000;
      errors++;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
